// File: rtl/trace_serialiser_pkg.sv
// Shared trace types for the serialiser: record layout, FSM states and the
// helper that sizes a record in output words.
package gouram_datatypes;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] cycle;
    } trace_format;

    localparam int unsigned TRACE_BITS = $bits(trace_format);

    function automatic int unsigned trace_words(input int unsigned bits,
                                                input int unsigned word_width);
        return (bits + word_width - 1) / word_width;
    endfunction

    localparam int unsigned TRACE_WORDS = trace_words(TRACE_BITS, 32);

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } ser_state_e;

endpackage

// File: rtl/trace_serialiser_fifo.sv
// Record FIFO for the serialiser; the caller is responsible for never pushing
// when full without a matching pop, and never popping when empty.
module trace_record_fifo
    import gouram_datatypes::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter type         T     = trace_format
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  T                         data_i,
    input  logic                     pop_i,
    output T                         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    T                mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [PW:0]     count_q;
    logic [PW:0]     count_d;

    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + 1'b1;
        end else if (pop_i && !push_i) begin
            count_d = count_q - 1'b1;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/trace_serialiser.sv
// Buffers trace records and emits each one as a little-endian sequence of
// WORD_WIDTH-bit words over a valid/ready stream, counting dropped records.
module trace_serialiser
    import gouram_datatypes::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned WORD_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          trace_valid_i,
    input  trace_format                   trace_data_i,
    input  logic                          flush_i,
    output logic                          word_valid_o,
    output logic [WORD_WIDTH-1:0]         word_data_o,
    output logic                          word_last_o,
    input  logic                          word_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic [15:0]                   drop_count_o,
    output logic                          overflow_o
);

    localparam int unsigned N        = trace_words(TRACE_BITS, WORD_WIDTH);
    localparam int unsigned IDXW     = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CNTW     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    ser_state_e            state_q, state_d;
    logic [IDXW-1:0]       idx_q, idx_d;
    logic [15:0]           drop_q, drop_d;
    logic                  ovf_q, ovf_d;

    trace_format           head;
    logic [N*WORD_WIDTH-1:0] head_padded;
    logic                  fifo_full, fifo_empty;
    logic                  sending, is_last, hs, last_hs;
    logic                  push, pop, drop;

    trace_record_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (trace_format)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush_i),
        .push_i  (push),
        .data_i  (trace_data_i),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count_o)
    );

    assign sending = (state_q == ST_SEND);
    assign is_last = (idx_q == LAST_IDX);
    assign hs      = sending && word_ready_i;
    assign last_hs = hs && is_last;

    // A full FIFO still accepts a record when its head leaves this cycle.
    assign pop  = last_hs && !flush_i;
    assign push = trace_valid_i && (!fifo_full || last_hs) && !flush_i;
    assign drop = trace_valid_i && fifo_full && !last_hs && !flush_i;

    always_comb begin
        head_padded                 = '0;
        head_padded[TRACE_BITS-1:0] = head;
    end

    always_comb begin
        word_valid_o = 1'b0;
        word_last_o  = 1'b0;
        word_data_o  = '0;
        if (sending) begin
            word_valid_o = 1'b1;
            word_last_o  = is_last;
            word_data_o  = head_padded[int'(idx_q)*WORD_WIDTH +: WORD_WIDTH];
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_SEND;
                    idx_d   = '0;
                end
            end
            ST_SEND: begin
                if (hs) begin
                    if (is_last) begin
                        idx_d   = '0;
                        state_d = ((fifo_count_o > CNTW'(1)) || push) ? ST_SEND : ST_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
        if (flush_i) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end
    end

    always_comb begin
        drop_d = drop_q;
        ovf_d  = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != '1) begin
                drop_d = drop_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            drop_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drop_q  <= drop_d;
            ovf_q   <= ovf_d;
        end
    end

    assign drop_count_o = drop_q;
    assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_trace_serialiser.sv
// Scoreboard bench for trace_serialiser with 32-bit words, 96-bit records, depth 4.
module tb_trace_serialiser;
    import gouram_datatypes::*;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        trace_valid;
    trace_format trace_data;
    logic        flush;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_last;
    logic        word_ready;
    logic [2:0]  fifo_count;
    logic [15:0] drop_count;
    logic        overflow;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    trace_serialiser #(
        .FIFO_DEPTH (4),
        .WORD_WIDTH (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .trace_valid_i (trace_valid),
        .trace_data_i  (trace_data),
        .flush_i       (flush),
        .word_valid_o  (word_valid),
        .word_data_o   (word_data),
        .word_last_o   (word_last),
        .word_ready_i  (word_ready),
        .fifo_count_o  (fifo_count),
        .drop_count_o  (drop_count),
        .overflow_o    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic trace_format mk(input int i);
        trace_format r;
        r.pc    = 32'hA000_0000 + i;
        r.instr = 32'hB000_0000 + i;
        r.cycle = 32'hC000_0000 + i;
        return r;
    endfunction

    // Expected order: low 32 bits first, i.e. C, then B, then A (last).
    task automatic expect_rec(input int i);
        exp_q.push_back('{d: 32'hC000_0000 + i, l: 1'b0});
        exp_q.push_back('{d: 32'hB000_0000 + i, l: 1'b0});
        exp_q.push_back('{d: 32'hA000_0000 + i, l: 1'b1});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int i);
        trace_valid = 1'b1;
        trace_data  = mk(i);
        step();
        trace_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && word_valid && word_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_word: got %0h, expected no word", word_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("word_data", word_data, e.d);
                check("word_last", word_last, e.l);
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        trace_valid = 1'b0;
        trace_data  = '0;
        flush       = 1'b0;
        word_ready  = 1'b0;
        #1;
        check("rst_valid", word_valid, 0);
        check("rst_last",  word_last,  0);
        check("rst_data",  word_data,  0);
        check("rst_count", fifo_count, 0);
        check("rst_drop",  drop_count, 0);
        check("rst_ovf",   overflow,   0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // single record, ready held high
        word_ready = 1'b1;
        expect_rec(1);
        send(1);
        check("t1_count_after_push", fifo_count, 1);
        check("t1_valid_before", word_valid, 0);
        step();
        check("t1_latency_valid", word_valid, 1);
        check("t1_first_last", word_last, 0);
        repeat (3) step();
        check("t1_count_after_pop", fifo_count, 0);
        check("t1_valid_idle", word_valid, 0);

        // stall during word 1
        word_ready = 1'b0;
        expect_rec(2);
        send(2);
        step();
        word_ready = 1'b1;
        step();
        word_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("t2_hold_valid", word_valid, 1);
            check("t2_hold_data",  word_data,  32'hB000_0002);
            check("t2_hold_last",  word_last,  0);
        end
        word_ready = 1'b1;
        step();
        check("t2_last_word", word_last, 1);
        step();
        check("t2_count_done", fifo_count, 0);
        word_ready = 1'b0;

        // overflow: six records into depth 4
        for (int i = 10; i < 16; i++) begin
            trace_valid = 1'b1;
            trace_data  = mk(i);
            if (i < 14) expect_rec(i);
            step();
        end
        trace_valid = 1'b0;
        check("t3_count_full", fifo_count, 4);
        check("t3_drop", drop_count, 2);
        check("t3_ovf", overflow, 1);
        word_ready = 1'b1;
        repeat (12) step();
        check("t3_count_drained", fifo_count, 0);
        check("t3_valid_idle", word_valid, 0);
        word_ready = 1'b0;

        // push into full FIFO while head's last word leaves
        for (int i = 20; i < 24; i++) begin
            expect_rec(i);
            send(i);
        end
        check("t4_count_full", fifo_count, 4);
        word_ready = 1'b1;
        step();
        step();
        check("t4_at_last", word_last, 1);
        trace_valid = 1'b1;
        trace_data  = mk(24);
        expect_rec(24);
        step();
        trace_valid = 1'b0;
        check("t4_count_stays", fifo_count, 4);
        check("t4_drop_unchanged", drop_count, 2);
        repeat (12) step();
        check("t4_count_drained", fifo_count, 0);
        word_ready = 1'b0;

        // flush during word 1 with a coincident trace_valid
        for (int i = 30; i < 33; i++) begin
            expect_rec(i);
            send(i);
        end
        word_ready = 1'b1;
        step();
        word_ready  = 1'b0;
        flush       = 1'b1;
        trace_valid = 1'b1;
        trace_data  = mk(33);
        step();
        flush       = 1'b0;
        trace_valid = 1'b0;
        exp_q.delete();
        check("t5_valid", word_valid, 0);
        check("t5_count", fifo_count, 0);
        check("t5_drop_kept", drop_count, 2);
        check("t5_ovf_kept", overflow, 1);
        step();
        check("t5_count_no_push", fifo_count, 0);

        // asynchronous reset mid-record
        expect_rec(40);
        send(40);
        step();
        word_ready = 1'b1;
        step();
        word_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("t6_valid", word_valid, 0);
        check("t6_last",  word_last,  0);
        check("t6_data",  word_data,  0);
        check("t6_count", fifo_count, 0);
        check("t6_drop",  drop_count, 0);
        check("t6_ovf",   overflow,   0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        word_ready = 1'b1;
        expect_rec(41);
        send(41);
        check("t6_valid_before", word_valid, 0);
        step();
        check("t6_restart_word0", word_data, 32'hC000_0029);
        repeat (3) step();
        check("t6_count_done", fifo_count, 0);
        word_ready = 1'b0;
        step();

        check("leftover_expected", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
